// File: rtl/inst_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, field layout,
// memory geometry and FSM state encoding.
package definitions;

    localparam int INST_MEM_DEPTH = 8;
    localparam int INST_MEM_SIZE  = 32;
    localparam int OPCODE_W       = 4;
    localparam int OPERAND_W      = 16;

    typedef enum logic [OPCODE_W-1:0] {
        INST_NOP    = 4'h0,
        INST_MATMUL = 4'h1,
        INST_ACCMOV = 4'h2,
        INST_REPEAT = 4'hE,
        INST_HALT   = 4'hF
    } instruction_type;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_REPEAT = 3'd4,
        S_DONE   = 3'd5
    } seq_state_t;

endpackage

// File: rtl/inst_sequencer_repeat_counter.sv
// Loadable down-counter for REPEAT expansion, plus the iteration incrementer.
module repeat_counter #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [COUNT_WIDTH-1:0] load_val,
    input  logic                   dec,
    input  logic [COUNT_WIDTH-1:0] iter,
    output logic                   cnt_zero,
    output logic                   cnt_last,
    output logic [COUNT_WIDTH-1:0] iter_next
);

    logic [COUNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && !cnt_zero) begin
            cnt <= cnt - COUNT_WIDTH'(1);
        end
    end

    assign cnt_zero  = (cnt == '0);
    // last = the handshake in flight consumes the final repeat
    assign cnt_last  = (cnt == COUNT_WIDTH'(1));
    assign iter_next = iter + COUNT_WIDTH'(1);

endmodule

// File: rtl/inst_sequencer.sv
// Fetches instruction words, expands REPEAT into operand-incrementing reissues,
// and hands instructions to the decoder over a valid/ready handshake.
module inst_sequencer #(
    parameter int INST_MEM_DEPTH = definitions::INST_MEM_DEPTH,
    parameter int INST_MEM_SIZE  = definitions::INST_MEM_SIZE,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic [INST_MEM_DEPTH-1:0] inst_addr,
    input  logic [INST_MEM_SIZE-1:0]  inst_data,
    output logic                      issue_valid,
    input  logic                      issue_ready,
    output logic [3:0]                issue_opcode,
    output logic [COUNT_WIDTH-1:0]    issue_operand,
    output logic [COUNT_WIDTH-1:0]    issue_iter,
    output logic                      issue_first
);

    import definitions::*;

    seq_state_t             state;
    logic [COUNT_WIDTH-1:0] base_operand;
    logic                   has_base;

    logic [OPCODE_W-1:0]    opc;
    logic [COUNT_WIDTH-1:0] field;
    logic                   hs, last_addr, rep_take, word_done;
    logic                   rc_zero, rc_last;
    logic [COUNT_WIDTH-1:0] iter_next;

    assign opc       = inst_data[INST_MEM_SIZE-1 -: OPCODE_W];
    assign field     = COUNT_WIDTH'(inst_data[OPERAND_W-1:0]);
    assign hs        = issue_valid && issue_ready;
    assign last_addr = &inst_addr;
    // a REPEAT only expands when there is a base to repeat and a nonzero length
    assign rep_take  = (state == S_DECODE) && (opc == INST_REPEAT) && has_base && (field != '0);

    logic unused_bits;
    assign unused_bits = &{1'b0, inst_data[INST_MEM_SIZE-OPCODE_W-1:OPERAND_W], rc_zero};

    repeat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_rep (
        .clk       (clk),
        .reset     (reset),
        .load      (rep_take),
        .load_val  (field),
        .dec       ((state == S_REPEAT) && hs),
        .iter      (issue_iter),
        .cnt_zero  (rc_zero),
        .cnt_last  (rc_last),
        .iter_next (iter_next)
    );

    // The current word is fully consumed this cycle: advance or run off the end.
    always_comb begin
        word_done = 1'b0;
        case (state)
            S_DECODE: word_done = (opc == INST_REPEAT) && !rep_take;
            S_ISSUE:  word_done = hs;
            S_REPEAT: word_done = hs && rc_last;
            default:  word_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            inst_addr     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            overflow      <= 1'b0;
            issue_valid   <= 1'b0;
            issue_opcode  <= '0;
            issue_operand <= '0;
            issue_iter    <= '0;
            issue_first   <= 1'b1;
            base_operand  <= '0;
            has_base      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_FETCH;
                        inst_addr <= '0;
                        overflow  <= 1'b0;
                        busy      <= 1'b1;
                        has_base  <= 1'b0;
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    if (opc == INST_HALT) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (rep_take) begin
                        state         <= S_REPEAT;
                        issue_valid   <= 1'b1;
                        issue_iter    <= iter_next;
                        issue_operand <= base_operand + iter_next;
                        issue_first   <= (iter_next == '0);
                    end else if (opc != INST_REPEAT) begin
                        state         <= S_ISSUE;
                        issue_valid   <= 1'b1;
                        issue_opcode  <= opc;
                        issue_operand <= field;
                        issue_iter    <= '0;
                        issue_first   <= 1'b1;
                        base_operand  <= field;
                        has_base      <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (hs) issue_valid <= 1'b0;
                end
                S_REPEAT: begin
                    if (hs) begin
                        if (rc_last) begin
                            issue_valid <= 1'b0;
                        end else begin
                            issue_iter    <= iter_next;
                            issue_operand <= base_operand + iter_next;
                            issue_first   <= (iter_next == '0);
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (word_done) begin
                if (last_addr) begin
                    overflow <= 1'b1;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= S_DONE;
                end else begin
                    inst_addr <= inst_addr + 1'b1;
                    state     <= S_FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_sequencer.sv
// Scoreboard bench for inst_sequencer: directed programs in a behavioural
// synchronous memory, expected issues queued by the stimulus, checked by a monitor.
module tb_inst_sequencer;
    import definitions::*;

    localparam int D = 3;
    localparam int W = 32;
    localparam int C = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         busy, done, overflow;
    logic [D-1:0] inst_addr;
    logic [W-1:0] inst_data;
    logic         issue_valid;
    logic         issue_ready;
    logic [3:0]   issue_opcode;
    logic [C-1:0] issue_operand, issue_iter;
    logic         issue_first;

    inst_sequencer #(.INST_MEM_DEPTH(D), .INST_MEM_SIZE(W), .COUNT_WIDTH(C)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .overflow(overflow), .inst_addr(inst_addr), .inst_data(inst_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_opcode(issue_opcode), .issue_operand(issue_operand),
        .issue_iter(issue_iter), .issue_first(issue_first)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mem [2**D];
    always @(posedge clk) inst_data <= mem[inst_addr];

    typedef struct packed {
        logic [3:0]   op;
        logic [C-1:0] operand;
        logic [C-1:0] iter;
        logic         first;
    } exp_t;

    exp_t exp_q[$];
    int   hs_cyc[$];
    int   errors = 0, checks = 0, cyc = 0, st_cyc = 0, done_cyc = 0;
    bit   bp_en = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Ready driver: high, or a repeating 1,0,0,1 pattern under backpressure.
    initial begin
        int k;
        k = 0;
        issue_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            k++;
            issue_ready = bp_en ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
        end
    end

    // Monitor: every presented issue must match the queue head; pop on handshake.
    always @(negedge clk) begin
        if (reset && issue_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got op=%0h operand=%0h iter=%0h expected none",
                         issue_opcode, issue_operand, issue_iter);
            end else begin
                chk("issue", 64'({issue_opcode, issue_operand, issue_iter, issue_first}), 64'(exp_q[0]));
                if (issue_ready) begin
                    void'(exp_q.pop_front());
                    hs_cyc.push_back(cyc);
                end
            end
        end
    end

    function automatic logic [W-1:0] w(input logic [3:0] op, input logic [15:0] v);
        return {op, 12'h000, v};
    endfunction

    task automatic push(input logic [3:0] op, input int operand, input int iter);
        exp_q.push_back('{op: op, operand: C'(operand), iter: C'(iter), first: (iter == 0)});
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 2**D; i++) mem[i] = w(INST_HALT, 16'h0);
    endtask

    task automatic pulse_start();
        hs_cyc.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        st_cyc = cyc;
    endtask

    task automatic run_prog(input string nm, input logic exp_ovf);
        bit seen;
        seen = 0;
        pulse_start();
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk); #1;
            if (done) begin
                seen = 1;
                done_cyc = cyc;
                chk({nm, "_busy_at_done"}, 64'(busy), 64'(0));
                chk({nm, "_overflow"}, 64'(overflow), 64'(exp_ovf));
            end
        end
        if (!seen) chk({nm, "_done_timeout"}, 64'(0), 64'(1));
        chk({nm, "_all_issued"}, 64'(exp_q.size()), 64'(0));
        @(negedge clk); #1;
        chk({nm, "_done_pulse"}, 64'(done), 64'(0));
        exp_q.delete();
    endtask

    initial begin
        clear_mem();
        repeat (3) @(negedge clk);
        chk("rst_outputs", 64'({busy, done, overflow, issue_valid, issue_first}), 64'(5'b00001));
        chk("rst_fields", 64'({inst_addr, issue_opcode, issue_operand, issue_iter}), 64'(0));
        reset = 1'b1;

        // single issue + latency/done timing
        clear_mem();
        mem[0] = w(INST_MATMUL, 16'd5);
        push(INST_MATMUL, 5, 0);
        run_prog("t1", 1'b0);
        chk("t1_issue_lat", 64'(hs_cyc.size() > 0 ? hs_cyc[0] - st_cyc : -1), 64'(2));
        chk("t1_done_lat", 64'(done_cyc - st_cyc), 64'(5));

        // base + REPEAT 3, repeats back-to-back
        clear_mem();
        mem[0] = w(INST_MATMUL, 16'd10);
        mem[1] = w(INST_REPEAT, 16'd3);
        for (int i = 0; i < 4; i++) push(INST_MATMUL, 10 + i, i);
        run_prog("t2", 1'b0);
        chk("t2_count", 64'(hs_cyc.size()), 64'(4));
        for (int i = 1; i < 3 && i + 1 < hs_cyc.size(); i++)
            chk("t2_consecutive", 64'(hs_cyc[i+1] - hs_cyc[i]), 64'(1));

        // leading REPEAT and REPEAT 0 are skipped
        clear_mem();
        mem[0] = w(INST_REPEAT, 16'd4);
        mem[1] = w(INST_ACCMOV, 16'd0);
        mem[2] = w(INST_REPEAT, 16'd0);
        push(INST_ACCMOV, 0, 0);
        run_prog("t3", 1'b0);
        chk("t3_count", 64'(hs_cyc.size()), 64'(1));

        // chained REPEATs keep numbering
        clear_mem();
        mem[0] = w(INST_MATMUL, 16'd3);
        mem[1] = w(INST_REPEAT, 16'd2);
        mem[2] = w(INST_REPEAT, 16'd3);
        for (int i = 0; i < 6; i++) push(INST_MATMUL, 3 + i, i);
        run_prog("t4", 1'b0);

        // operand wraps modulo 2^16
        clear_mem();
        mem[0] = w(INST_ACCMOV, 16'hFFFE);
        mem[1] = w(INST_REPEAT, 16'd2);
        push(INST_ACCMOV, 16'hFFFE, 0);
        push(INST_ACCMOV, 16'hFFFF, 1);
        push(INST_ACCMOV, 16'h0000, 2);
        run_prog("t5", 1'b0);

        // backpressure during REPEAT 2
        clear_mem();
        mem[0] = w(INST_MATMUL, 16'd7);
        mem[1] = w(INST_REPEAT, 16'd2);
        for (int i = 0; i < 3; i++) push(INST_MATMUL, 7 + i, i);
        bp_en = 1;
        run_prog("t6", 1'b0);
        bp_en = 0;
        chk("t6_count", 64'(hs_cyc.size()), 64'(3));

        // run off the end of memory
        for (int i = 0; i < 2**D; i++) begin
            mem[i] = w(INST_MATMUL, 16'(i));
            push(INST_MATMUL, i, 0);
        end
        run_prog("t7", 1'b1);
        chk("t7_count", 64'(hs_cyc.size()), 64'(8));
        repeat (3) @(negedge clk);
        chk("t7_ovf_sticky", 64'(overflow), 64'(1));
        clear_mem();
        run_prog("t7b", 1'b0);

        // REPEAT at the last address finishes, then overflows
        for (int i = 0; i < 6; i++) mem[i] = w(INST_REPEAT, 16'd0);
        mem[6] = w(INST_MATMUL, 16'd100);
        mem[7] = w(INST_REPEAT, 16'd2);
        for (int i = 0; i < 3; i++) push(INST_MATMUL, 100 + i, i);
        run_prog("t8", 1'b1);

        // HALT at the last address is a normal stop
        mem[0] = w(INST_MATMUL, 16'd1);
        for (int i = 1; i < 7; i++) mem[i] = w(INST_REPEAT, 16'd0);
        mem[7] = w(INST_HALT, 16'd0);
        push(INST_MATMUL, 1, 0);
        run_prog("t9", 1'b0);

        // reset mid-REPEAT, then rerun from address 0
        clear_mem();
        mem[0] = w(INST_MATMUL, 16'd20);
        mem[1] = w(INST_REPEAT, 16'd5);
        for (int i = 0; i < 3; i++) push(INST_MATMUL, 20 + i, i);
        pulse_start();
        begin
            bit hit;
            hit = 0;
            for (int k = 0; k < 100 && !hit; k++) begin
                @(negedge clk); #1;
                if (hs_cyc.size() == 3) hit = 1;
            end
            if (!hit) chk("t10_reach_timeout", 64'(0), 64'(1));
        end
        reset = 1'b0;
        #1;
        chk("t10_rst_valid", 64'(issue_valid), 64'(0));
        chk("t10_rst_addr", 64'(inst_addr), 64'(0));
        chk("t10_rst_busy", 64'(busy), 64'(0));
        chk("t10_rst_first", 64'(issue_first), 64'(1));
        @(posedge clk); #1;
        chk("t10_rst_hold", 64'({issue_valid, busy, inst_addr}), 64'(0));
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) push(INST_MATMUL, 20 + i, i);
        run_prog("t10", 1'b0);
        chk("t10_count", 64'(hs_cyc.size()), 64'(6));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
